// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered read port.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_SIZE  = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_SIZE:0]    count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [ADDR_SIZE:0]   FULL_CNT = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0]   AF_CNT   = (ADDR_SIZE+1)'(AF_LEVEL);
  localparam logic [ADDR_SIZE:0]   AE_CNT   = (ADDR_SIZE+1)'(AE_LEVEL);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE  = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0]   CNT_ONE  = (ADDR_SIZE+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_fire, rd_fire;

  // Status flags decode straight from the registered occupancy, so they never glitch on inputs.
  assign full_o         = (count_q == FULL_CNT);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AF_CNT);
  assign almost_empty_o = (count_q <= AE_CNT);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  assign wr_fire = wr_en_i & ~full_o  & ~flush_i;
  assign rd_fire = rd_en_i & ~empty_o & ~flush_i;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (wr_en_i & full_o  & ~flush_i);
    underflow_d = underflow_q | (rd_en_i & empty_o & ~flush_i);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

`ifdef FIFO_FWFT_EN
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign rd_valid_o = ~empty_o;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_fire ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_fire;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
// Table-driven fill vectors plus hand-written corner sequences, all data checked via a scoreboard queue.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] sb[$];
  int            m_count;
  logic          m_ovf, m_udf;

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic          rd;
    logic          fl;
    int            cnt;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
  } vec_t;

  vec_t vecs[8];

  sync_fifo_prog #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_SIZE  (AW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .wr_en_i        (wr_en),
    .wr_data_i      (wr_data),
    .rd_en_i        (rd_en),
    .rd_data_o      (rd_data),
    .rd_valid_o     (rd_valid),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty),
    .count_o        (count),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, count, m_count);
    check({tag, "_full"}, full, m_count == DEPTH);
    check({tag, "_empty"}, empty, m_count == 0);
    check({tag, "_af"}, almost_full, m_count >= AF);
    check({tag, "_ae"}, almost_empty, m_count <= AE);
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_udf"}, underflow, m_udf);
  endtask

  // One clock of stimulus; the model decides acceptance and the scoreboard tracks data order.
  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd, input logic fl);
    logic          wa, ra;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    flush   = fl;
    wa = wr && !fl && (m_count < DEPTH);
    ra = rd && !fl && (m_count > 0);
    #1;
`ifdef FIFO_FWFT_EN
    if (ra) check("fwft_data", rd_data, sb[0]);
`endif
    if (fl) begin
      sb.delete();
      m_count = 0;
    end else begin
      if (wr && !wa) m_ovf = 1'b1;
      if (rd && !ra) m_udf = 1'b1;
      if (wa) sb.push_back(d);
      m_count = m_count + int'(wa) - int'(ra);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
`ifdef FIFO_FWFT_EN
    if (ra) exp_d = sb.pop_front();
    check("fwft_valid", rd_valid, m_count > 0);
`else
    check("rd_valid", rd_valid, ra);
    if (rd_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_data: got 0x%0h, expected no data (scoreboard empty) at %0t", rd_data, $time);
      end else begin
        exp_d = sb.pop_front();
        check("rd_data", rd_data, exp_d);
      end
    end
`endif
    check_status("cyc");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h05, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h06, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'h07, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'h08, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0};

    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;

    // Asynchronous reset state before any clock edge.
    #2;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
`ifndef FIFO_FWFT_EN
    check("rst_data", rd_data, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x01..0x08, checking flag thresholds against the table.
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].fl);
      check("vec_count", count, vecs[i].cnt);
      check("vec_full", full, vecs[i].full);
      check("vec_empty", empty, vecs[i].empty);
      check("vec_af", almost_full, vecs[i].af);
      check("vec_ae", almost_empty, vecs[i].ae);
    end

    // Overflow from full, then drain in order.
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 8);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", empty, 1);
    check("drain_sb", sb.size(), 0);

    // Read and write together while empty: read dropped, write kept.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    check("udf_set", underflow, 1);
    check("udf_count", count, 1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("udf_drain_sb", sb.size(), 0);

    // Steady state at COUNT=4 across pointer wrap.
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
    check("hold_count", count, 4);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("hold_drain_sb", sb.size(), 0);

    // Flush at COUNT=5 beats a same-cycle write; sticky flags survive.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_ovf", overflow, 1);
    check("flush_udf", underflow, 1);
    cycle(1'b1, 8'h81, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-cycle with COUNT=3 acts without a clock edge.
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_ae", almost_empty, 1);
    check("mid_rst_af", almost_full, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_udf", underflow, 0);
    check("mid_rst_valid", rd_valid, 0);
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_sb", sb.size(), 0);
    check("post_rst_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
